set_scan_ctrl: RTL and testbench

//  Job controller that feeds the combinational Venn-subset evaluator. Accepts one job
//  (three circle centres, three radii, mode) and squares the radii. Sweeps every grid

---
 rtl/set_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_set_scan_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/set_scan_ctrl.sv
// ---------------------------------------------------------------------------
// set_scan_ctrl
//   Job controller for the combinational Venn-subset evaluator. One job
//   (three circle centres, three radii, mode) is latched, the radii are
//   squared, and every grid point (1..GRID, 1..GRID) is presented to the
//   evaluator, one point per cycle. The points the evaluator flags are
//   counted, and the total is reported with a one-cycle valid pulse.
//
// Parameters
//   GRID   grid edge; coordinates run 1..GRID (<= 15, fits 4 bits)
//   CNT_W  counter width; must hold GRID*GRID
//
// Ports
//   clk                in   system clock, rising edge
//   rst_n              in   synchronous reset, active low
//   en                 in   job start request, sampled only while busy==0
//   central_in         in   {xA,yA,xB,yB,xC,yC}, 4 bits each
//   radius_in          in   {rA,rB,rC}, 4 bits each
//   mode_in            in   set-operation select, passed through
//   busy               out  job in progress
//   valid              out  one-cycle pulse, candidate holds a new result
//   candidate          out  activated-point count of the last job
//   sub_central        out  latched centres, to evaluator
//   sub_radius_square  out  {rA^2,rB^2,rC^2}, 8 bits each, to evaluator
//   sub_mode           out  latched mode, to evaluator
//   sub_position       out  {x,y} point currently evaluated
//   sub_activated      in   evaluator result for sub_position
// ---------------------------------------------------------------------------
module set_scan_ctrl #(
   parameter int GRID  = 8,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [23:0]      central_in,
   input  logic [11:0]      radius_in,
   input  logic [1:0]       mode_in,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] candidate,
   output logic [23:0]      sub_central,
   output logic [23:0]      sub_radius_square,
   output logic [1:0]       sub_mode,
   output logic [7:0]       sub_position,
   input  logic             sub_activated
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] W_LAST = 4'(GRID);

   logic [1:0]       r_state;
   logic             r_busy;
   logic             r_valid;
   logic [CNT_W-1:0] r_cand;
   logic [CNT_W-1:0] r_count;
   logic [23:0]      r_central;
   logic [23:0]      r_rsq;
   logic [1:0]       r_mode;
   logic [3:0]       r_x;
   logic [3:0]       r_y;

   logic [CNT_W-1:0] w_cnt_next;
   logic             w_last;
   logic [7:0]       w_ra;
   logic [7:0]       w_rb;
   logic [7:0]       w_rc;

   always_comb begin
      w_ra       = {4'b0, radius_in[11:8]};
      w_rb       = {4'b0, radius_in[7:4]};
      w_rc       = {4'b0, radius_in[3:0]};
      w_cnt_next = r_count + {{(CNT_W-1){1'b0}}, sub_activated};
      w_last     = (r_x == W_LAST) && (r_y == W_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_cand    <= '0;
         r_count   <= '0;
         r_central <= '0;
         r_rsq     <= '0;
         r_mode    <= '0;
         r_x       <= 4'd1;
         r_y       <= 4'd1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_valid <= 1'b0;
               if (en) begin
                  r_central <= central_in;
                  r_mode    <= mode_in;
                  r_rsq     <= {w_ra * w_ra, w_rb * w_rb, w_rc * w_rc};
                  r_count   <= '0;
                  r_x       <= 4'd1;
                  r_y       <= 4'd1;
                  r_busy    <= 1'b1;
                  r_state   <= S_SCAN;
               end
            end
            S_SCAN: begin
               r_count <= w_cnt_next;
               if (w_last) begin
                  // Last point's flag is folded in here, so the result is
                  // presented together with valid in the DONE cycle.
                  r_cand  <= w_cnt_next;
                  r_valid <= 1'b1;
                  r_x     <= 4'd1;
                  r_y     <= 4'd1;
                  r_state <= S_DONE;
               end else if (r_y == W_LAST) begin
                  r_y <= 4'd1;
                  r_x <= r_x + 4'd1;
               end else begin
                  r_y <= r_y + 4'd1;
               end
            end
            S_DONE: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy              = r_busy;
   assign valid             = r_valid;
   assign candidate         = r_cand;
   assign sub_central       = r_central;
   assign sub_radius_square = r_rsq;
   assign sub_mode          = r_mode;
   assign sub_position      = {r_x, r_y};

endmodule

// File: tb/tb_set_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_set_scan_ctrl
//   Self-checking bench for set_scan_ctrl. A behavioural evaluator model
//   drives sub_activated (constant, circle-A membership, or a parity
//   pattern). Expected counts are queued when a job is started and
//   compared when valid is seen.
// ---------------------------------------------------------------------------
module tb_set_scan_ctrl;

   localparam int GRID  = 8;
   localparam int CNT_W = 7;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [23:0]      central_in;
   logic [11:0]      radius_in;
   logic [1:0]       mode_in;
   logic             busy;
   logic             valid;
   logic [CNT_W-1:0] candidate;
   logic [23:0]      sub_central;
   logic [23:0]      sub_radius_square;
   logic [1:0]       sub_mode;
   logic [7:0]       sub_position;
   logic             sub_activated;

   int act_sel;
   int n_checks;
   int n_errors;
   int sb_q[$];

   typedef struct {
      logic [23:0] central;
      logic [11:0] radius;
      logic [1:0]  mode;
      int          sel;
      int          exp_cnt;
      logic [23:0] exp_rsq;
   } vec_t;

   vec_t tbl[5];

   set_scan_ctrl #(.GRID(GRID), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .en                (en),
      .central_in        (central_in),
      .radius_in         (radius_in),
      .mode_in           (mode_in),
      .busy              (busy),
      .valid             (valid),
      .candidate         (candidate),
      .sub_central       (sub_central),
      .sub_radius_square (sub_radius_square),
      .sub_mode          (sub_mode),
      .sub_position      (sub_position),
      .sub_activated     (sub_activated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // sel 0: always 1, 1: always 0, 2: inside circle A, 3: x+y odd
   function automatic logic model_act(input int sel, input logic [7:0] pos,
                                      input logic [23:0] cen, input logic [23:0] rsq);
      int dx;
      int dy;
      dx = int'(pos[7:4]) - int'(cen[23:20]);
      dy = int'(pos[3:0]) - int'(cen[19:16]);
      case (sel)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (dx * dx + dy * dy) <= int'(rsq[23:16]);
         3:       return pos[4] ^ pos[0];
         default: return 1'b0;
      endcase
   endfunction

   always_comb sub_activated = model_act(act_sel, sub_position, sub_central, sub_radius_square);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},   32'(busy), 32'd0);
      check({tag, "_valid"},  32'(valid), 32'd0);
      check({tag, "_cand"},   32'(candidate), 32'd0);
      check({tag, "_pos"},    32'(sub_position), 32'h11);
      check({tag, "_cen"},    32'(sub_central), 32'd0);
      check({tag, "_rsq"},    32'(sub_radius_square), 32'd0);
      check({tag, "_mode"},   32'(sub_mode), 32'd0);
   endtask

   // Runs one full job; called at a negedge with the DUT idle.
   task automatic run_job(input int idx, input bit hold, input bit mid_en);
      vec_t v;
      int   exp_c;
      logic [7:0] exp_pos;
      v          = tbl[idx];
      en         = 1'b1;
      central_in = v.central;
      radius_in  = v.radius;
      mode_in    = v.mode;
      act_sel    = v.sel;
      sb_q.push_back(v.exp_cnt);
      tick();
      if (!hold) en = 1'b0;
      // latched copies must not follow the inputs during the scan
      central_in = ~v.central;
      radius_in  = ~v.radius;
      mode_in    = ~v.mode;
      for (int k = 1; k <= GRID * GRID; k++) begin
         exp_pos = {4'((k - 1) / GRID + 1), 4'((k - 1) % GRID + 1)};
         check("scan_busy",  32'(busy), 32'd1);
         check("scan_valid", 32'(valid), 32'd0);
         check("scan_pos",   32'(sub_position), 32'(exp_pos));
         check("scan_rsq",   32'(sub_radius_square), 32'(v.exp_rsq));
         check("scan_cen",   32'(sub_central), 32'(v.central));
         check("scan_mode",  32'(sub_mode), 32'(v.mode));
         if (mid_en && k == 20) en = 1'b1;
         if (mid_en && k == 22) en = 1'b0;
         tick();
      end
      check("done_busy",  32'(busy), 32'd1);
      check("done_valid", 32'(valid), 32'd1);
      check("done_pos",   32'(sub_position), 32'h11);
      check("done_rsq",   32'(sub_radius_square), 32'(v.exp_rsq));
      if (sb_q.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
         exp_c = -1;
      end else begin
         exp_c = sb_q.pop_front();
         check("done_cand", 32'(candidate), 32'(exp_c));
      end
      tick();
      check("idle_busy",  32'(busy), 32'd0);
      check("idle_valid", 32'(valid), 32'd0);
      check("idle_cand",  32'(candidate), 32'(exp_c));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vcount;
      n_checks = 0;
      n_errors = 0;
      tbl[0] = '{24'h44_12_34, 12'h234, 2'b01, 0, 64, 24'h04_09_10};
      tbl[1] = '{24'h12_34_56, 12'hFFF, 2'b10, 1,  0, 24'hE1_E1_E1};
      tbl[2] = '{24'h44_88_88, 12'h211, 2'b00, 2, 13, 24'h04_01_01};
      tbl[3] = '{24'h11_00_00, 12'h3A5, 2'b11, 2, 11, 24'h09_64_19};
      tbl[4] = '{24'hAB_CD_EF, 12'h0F7, 2'b01, 3, 32, 24'h00_E1_31};

      rst_n = 1'b0; en = 1'b0; central_in = '0; radius_in = '0; mode_in = '0; act_sel = 0;
      @(negedge clk);
      tick();
      tick();
      check_reset_outputs("rst0");
      rst_n = 1'b1;
      tick();
      check("idle0_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 5; i++) run_job(i, 1'b0, 1'b0);

      // reset while idle clears the held result
      check("pre_rst_cand", 32'(candidate), 32'd32);
      rst_n = 1'b0;
      tick();
      tick();
      check_reset_outputs("rst1");
      rst_n = 1'b1;
      tick();

      // en pulse in mid-scan must not start a second job
      run_job(0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("no_requeue_busy",  32'(busy), 32'd0);
         check("no_requeue_valid", 32'(valid), 32'd0);
         tick();
      end

      // en held high: second job starts after exactly one idle cycle
      run_job(2, 1'b1, 1'b0);
      run_job(4, 1'b0, 1'b0);

      // reset at scan cycle 30 aborts the job without a result
      en = 1'b1; central_in = tbl[0].central; radius_in = tbl[0].radius;
      mode_in = tbl[0].mode; act_sel = 0;
      tick();
      en = 1'b0;
      for (int k = 1; k < 30; k++) tick();
      check("abort_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      check_reset_outputs("abort");
      rst_n = 1'b1;
      vcount = 0;
      for (int k = 0; k < 70; k++) begin
         if (valid === 1'b1) vcount++;
         tick();
      end
      check("abort_no_valid", 32'(vcount), 32'd0);
      check("abort_idle_busy", 32'(busy), 32'd0);

      run_job(3, 1'b0, 1'b0);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
